// File: rtl/tt_um_6bitsub_serial.sv
// Bit-serial subtractor tile: D = A - B - borrow_in, processed LSB first, one bit per clock.
// Ports: ui_in = {start, borrow_in, A}, uio_in[5:0] = B; uo_out = {done, borrow_out, D};
//        uio_out = {overflow, busy, 6'b0}, uio_oe fixed at 8'hC0. Latency 6 clocks from the trigger edge.
module tt_um_6bitsub_serial #(
  parameter int WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             start_q;
  logic             trigger;
  logic             last_bit;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic [WIDTH-1:0] d_full;
  logic [WIDTH-1:0] d_res;
  logic [5:0]       d_pad;

  logic             br;
  logic             br_nxt;
  logic             d_bit;
  logic             a_sign;
  logic             b_sign;
  logic             borrow_res;
  logic             ovf_res;
  logic             done_r;
  logic [2:0]       cnt;

  // ena is always high on a powered tile; upper uio_in bits carry nothing.
  logic             unused;
  assign unused = &{1'b0, ena, ui_in, uio_in};

  // Rising edge of start only, and only while idle: a held level or a
  // start during RUN never launches (or queues) another operation.
  assign trigger  = ui_in[7] & ~start_q & (state == IDLE);
  assign last_bit = (state == RUN) && (cnt == 3'(WIDTH - 1));

  // Full-subtractor on the current LSBs.
  assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  // Difference register shifts right with the new bit entering at the MSB,
  // so after WIDTH shifts bit 0 holds the first (LSB) result bit.
  always_comb begin
    d_full           = d_sr >> 1;
    d_full[WIDTH-1]  = d_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (trigger)  state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      d_res      <= '0;
      br         <= 1'b0;
      a_sign     <= 1'b0;
      b_sign     <= 1'b0;
      borrow_res <= 1'b0;
      ovf_res    <= 1'b0;
      done_r     <= 1'b0;
      cnt        <= '0;
    end else begin
      start_q <= ui_in[7];
      done_r  <= 1'b0;
      if (trigger) begin
        // Operand pins are free to change once captured here.
        a_sr   <= ui_in[WIDTH-1:0];
        b_sr   <= uio_in[WIDTH-1:0];
        a_sign <= ui_in[WIDTH-1];
        b_sign <= uio_in[WIDTH-1];
        br     <= ui_in[6];
        d_sr   <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        d_sr <= d_full;
        br   <= br_nxt;
        cnt  <= cnt + 3'd1;
        // Visible results change only here, never with partial sums.
        if (last_bit) begin
          d_res      <= d_full;
          borrow_res <= br_nxt;
          ovf_res    <= (a_sign != b_sign) & (d_bit != a_sign);
          done_r     <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    d_pad             = '0;
    d_pad[WIDTH-1:0]  = d_res;
  end

  assign uo_out  = {done_r, borrow_res, d_pad};
  assign uio_out = {ovf_res, (state == RUN), 6'b00_0000};
  assign uio_oe  = 8'b1100_0000;

endmodule

// File: tb/tb_tt_um_6bitsub_serial.sv
module tb_tt_um_6bitsub_serial;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int passed;
  int total;

  // Last completed result as the outputs should currently show it.
  logic [5:0] exp_d;
  logic       exp_bo;
  logic       exp_ov;

  tt_um_6bitsub_serial dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer subtraction; returns {overflow, borrow, diff}.
  function automatic logic [7:0] ref_sub(input logic [5:0] a, input logic [5:0] b, input logic bin);
    int         diff;
    logic [5:0] d;
    logic       bo;
    logic       ov;
    diff = int'(a) - int'(b) - int'(bin);
    d    = diff[5:0];
    bo   = (diff < 0);
    ov   = (a[5] != b[5]) && (d[5] != a[5]);
    return {ov, bo, d};
  endfunction

  // One complete operation from an idle negedge with start low; ends at the
  // negedge after E7. Operand pins are scrambled after E0.
  task automatic run_op(input logic [5:0] a, input logic [5:0] b, input logic bin, input string tag);
    logic [7:0] r;
    r      = ref_sub(a, b, bin);
    ui_in  = {1'b1, bin, a};
    uio_in = {2'b00, b};
    @(posedge clk);
    @(negedge clk);
    ui_in  = {1'b0, 7'($urandom)};
    uio_in = 8'($urandom);
    for (int k = 0; k < 6; k++) begin
      total++;
      if ({uo_out, uio_out} !== {1'b0, exp_bo, exp_d, exp_ov, 1'b1, 6'b0}) begin
        $display("FAIL %s run_cycle%0d: got uo=%h uio=%h want uo=%h uio=%h", tag, k,
                 uo_out, uio_out, {1'b0, exp_bo, exp_d}, {exp_ov, 1'b1, 6'b0});
      end else passed++;
      @(negedge clk);
    end
    exp_d  = r[5:0];
    exp_bo = r[6];
    exp_ov = r[7];
    total++;
    if ({uo_out, uio_out} !== {1'b1, exp_bo, exp_d, exp_ov, 1'b0, 6'b0}) begin
      $display("FAIL %s result: got uo=%h uio=%h want uo=%h uio=%h", tag,
               uo_out, uio_out, {1'b1, exp_bo, exp_d}, {exp_ov, 1'b0, 6'b0});
    end else passed++;
    @(negedge clk);
    total++;
    if (uo_out[7] !== 1'b0) begin
      $display("FAIL %s done_width: done=%b want 0 one cycle after result", tag, uo_out[7]);
    end else passed++;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ui_in  = 8'hFF;
    uio_in = 8'hFF;
    repeat (3) @(negedge clk);
    total++;
    if ({uo_out, uio_out, uio_oe} !== {8'h00, 8'h00, 8'hC0}) begin
      $display("FAIL reset_values: got uo=%h uio=%h oe=%h want 00 00 c0", uo_out, uio_out, uio_oe);
    end else passed++;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    rst_n  = 1'b1;
    @(negedge clk);
    total++;
    if ({uo_out, uio_out} !== 16'h0000) begin
      $display("FAIL reset_release: got uo=%h uio=%h want 00 00", uo_out, uio_out);
    end else passed++;
    exp_d  = 6'h00;
    exp_bo = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic test_directed();
    run_op(6'h15, 6'h07, 1'b0, "dir_15_07");
    run_op(6'h00, 6'h01, 1'b0, "dir_00_01");
    run_op(6'h10, 6'h10, 1'b1, "dir_10_10_bin");
    run_op(6'h20, 6'h01, 1'b0, "dir_ovf_neg");
    run_op(6'h1F, 6'h3F, 1'b0, "dir_ovf_pos");
    run_op(6'h3F, 6'h00, 1'b1, "dir_3f_00_bin");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_op(6'($urandom), 6'($urandom), 1'($urandom), "random");
    end
  endtask

  task automatic test_level_hold();
    int dones;
    dones  = 0;
    ui_in  = {2'b10, 6'h05};
    uio_in = 8'h02;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (uo_out[7] === 1'b1) dones++;
    end
    ui_in = 8'h00;
    total++;
    if (dones !== 1) begin
      $display("FAIL level_hold_dones: got %0d done pulses want 1", dones);
    end else passed++;
    exp_d  = 6'h03;
    exp_bo = 1'b0;
    exp_ov = 1'b0;
    total++;
    if ({uo_out[6:0], uio_out[7:6]} !== {exp_bo, exp_d, exp_ov, 1'b0}) begin
      $display("FAIL level_hold_result: got uo=%h uio=%h want D=03 idle", uo_out, uio_out);
    end else passed++;
    @(negedge clk);
  endtask

  task automatic test_ignored_restart();
    int dones;
    dones  = 0;
    ui_in  = {2'b10, 6'h09};
    uio_in = 8'h04;
    @(posedge clk);
    @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
    ui_in  = {2'b10, 6'h01};
    uio_in = 8'h02;
    @(negedge clk);
    ui_in = 8'h00;
    for (int c = 0; c < 16; c++) begin
      total++;
      if (dones == 0 && uo_out[7] !== 1'b1) begin
        if (uo_out[5:0] !== 6'h03) begin
          $display("FAIL restart_hold c%0d: got D=%h want held 03", c, uo_out[5:0]);
        end else passed++;
      end else begin
        if (uo_out[5:0] !== 6'h05 || uo_out[6] !== 1'b0) begin
          $display("FAIL restart_result c%0d: got D=%h bo=%b want 05 0", c, uo_out[5:0], uo_out[6]);
        end else passed++;
      end
      if (uo_out[7] === 1'b1) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 1) begin
      $display("FAIL restart_dones: got %0d done pulses want 1", dones);
    end else passed++;
    exp_d  = 6'h05;
    exp_bo = 1'b0;
    exp_ov = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int dones;
    dones  = 0;
    ui_in  = {2'b10, 6'h15};
    uio_in = 8'h07;
    @(posedge clk);
    @(negedge clk);
    ui_in = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({uo_out, uio_out, uio_oe} !== {8'h00, 8'h00, 8'hC0}) begin
      $display("FAIL reset_mid_immediate: got uo=%h uio=%h oe=%h want 00 00 c0", uo_out, uio_out, uio_oe);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (uo_out[7] === 1'b1 || uio_out[6] === 1'b1) dones++;
    end
    total++;
    if (dones !== 0 || uo_out !== 8'h00) begin
      $display("FAIL reset_mid_discard: got %0d done/busy cycles uo=%h want 0 00", dones, uo_out);
    end else passed++;
    exp_d  = 6'h00;
    exp_bo = 1'b0;
    exp_ov = 1'b0;
    run_op(6'h3F, 6'h3F, 1'b0, "after_reset_3f_3f");
  endtask

  task automatic test_back_to_back();
    logic [7:0] r1;
    logic [7:0] r2;
    logic [5:0] a2;
    logic [5:0] b2;
    logic       bin2;
    logic       want_busy;
    logic       want_done;
    a2     = 6'($urandom);
    b2     = 6'($urandom);
    bin2   = 1'($urandom);
    r1     = ref_sub(6'h2A, 6'h0B, 1'b1);
    r2     = ref_sub(a2, b2, bin2);
    ui_in  = {2'b11, 6'h2A};
    uio_in = 8'h0B;
    @(posedge clk);
    for (int c = 0; c <= 14; c++) begin
      @(negedge clk);
      want_busy = (c <= 5) || (c >= 7 && c <= 12);
      want_done = (c == 6) || (c == 13);
      total++;
      if ({uo_out[7], uio_out[6], uio_out[5:0], uio_oe} !== {want_done, want_busy, 6'b0, 8'hC0}) begin
        $display("FAIL b2b_ctrl E%0d: got done=%b busy=%b uio_lo=%h oe=%h want %b %b 00 c0", c,
                 uo_out[7], uio_out[6], uio_out[5:0], uio_oe, want_done, want_busy);
      end else passed++;
      if (c == 6 || c == 13) begin
        exp_d  = (c == 6) ? r1[5:0] : r2[5:0];
        exp_bo = (c == 6) ? r1[6] : r2[6];
        exp_ov = (c == 6) ? r1[7] : r2[7];
        total++;
        if ({uo_out[6:0], uio_out[7]} !== {exp_bo, exp_d, exp_ov}) begin
          $display("FAIL b2b_result E%0d: got bo=%b D=%h ov=%b want %b %h %b", c,
                   uo_out[6], uo_out[5:0], uio_out[7], exp_bo, exp_d, exp_ov);
        end else passed++;
      end
      if (c == 5) ui_in[7] = 1'b0;
      if (c == 6) begin
        ui_in  = {1'b1, bin2, a2};
        uio_in = {2'b00, b2};
      end
      if (c == 7) ui_in[7] = 1'b0;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    ena    = 1'b1;
    rst_n  = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    @(negedge clk);
    test_reset();
    test_directed();
    test_level_hold();
    test_ignored_restart();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tt_um_6bitsub_serial.md
Name: tt_um_6bitsub_serial

Overview:
- Bit-serial 6-bit subtractor: computes D = A - B - borrow_in, LSB first, one bit per clock.
- Complements the team's combinational 6-bit adder tile. Provides the inverse operation as a sequential tile with a start/busy/done handshake.
- Drops into the standard tile wrapper: same pin frame, dedicated inputs carry A and control, the bidirectional bank carries B and status.

Parameters:
- WIDTH, 6, operand/result width in bits. Legal 1..6; the pin map below is fixed at 6, and unused upper bits read 0.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ena  input  1  always 1 when powered; ignored
- ui_in  input  8  [5:0]=A, [6]=borrow_in, [7]=start
- uio_in  input  8  [5:0]=B; [7:6] unused
- uo_out  output  8  [5:0]=D result, [6]=borrow_out, [7]=done
- uio_out  output  8  [5:0]=0, [6]=busy, [7]=overflow
- uio_oe  output  8  constant 8'b1100_0000 (uio[7:6] outputs, rest inputs)

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values (rst_n=0): state=IDLE, D=0, borrow_out=0, done=0, busy=0, overflow=0, bit counter=0, operand shift registers=0, start_q=0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Trigger:
  - start_q registers ui_in[7] every cycle.
  - Trigger = start & ~start_q & (state==IDLE), i.e. a rising edge only. A level held high never retriggers.
  - A start edge while in RUN is ignored and does not queue.
- Edge E0 (trigger sampled):
  - Latch A, B, borrow_in into internal registers; br=borrow_in; cnt=0.
  - state->RUN, busy=1.
  - Operand pins are don't-care after E0.
- Edges E1..E6 (RUN), bit i=cnt, with a=A_sr[0] and b=B_sr[0]:
  - d = a ^ b ^ br
  - br' = (~a & b) | (~(a ^ b) & br)
  - Shift A_sr and B_sr right. Shift d into the MSB of the difference shift register. cnt++.
- Completion (edge E6, cnt==5):
  - D output register <= full difference; borrow_out <= final br'.
  - overflow <= (A[5] != B[5]) & (D[5] != A[5]), i.e. signed two's-complement overflow.
  - done=1 for exactly one cycle (E6..E7). state->IDLE, busy=0.
- Output holding:
  - D, borrow_out and overflow hold their last completed values through IDLE and through the next RUN.
  - They update only at completion, never with partial results.
- Latency: 6 cycles from the trigger edge to done/result valid.
- Throughput: a new trigger is accepted at E7 at the earliest. The earliest re-accept is E7 because start must be seen low on an edge before a new rising edge counts.
- done and a trigger at the same edge: trigger is evaluated against state==IDLE after E6, so a rising edge sampled at E7 starts the next operation.
- Reset mid-RUN: immediately returns to reset values. No done pulse; the in-flight operation is discarded.
- Width rule:
  - D is A - B - bin mod 64.
  - borrow_out=1 iff unsigned A < B + bin.
  - For WIDTH<6, the overflow sign bit is bit WIDTH-1.

Test Plan:
- A=0x15, B=0x07, bin=0, pulse start -> busy=1 for 6 cycles, done pulse at E6, D=0x0E, borrow_out=0, overflow=0.
- A=0x00, B=0x01, bin=0 -> D=0x3F, borrow_out=1, overflow=0. Then A=0x10, B=0x10, bin=1 -> D=0x3F, borrow_out=1.
- A=0x20 (-32), B=0x01 -> D=0x1F, overflow=1, borrow_out=0. A=0x1F, B=0x3F (31-(-1)) -> D=0x20, overflow=1, borrow_out=1.
- Hold start high 20 cycles with A=0x05, B=0x02 -> exactly one done pulse, D=0x03. Change A/B and re-pulse start during RUN -> ignored, result unchanged, previous D held until new completion.
- Start an op, assert rst_n=0 at cycle 3 -> all outputs 0 immediately, no done. Release and run A=0x3F, B=0x3F -> D=0x00, borrow_out=0.
- Back-to-back: drop start at E6, re-raise for E7 -> second done at E13. Check uio_oe==0xC0 and uio_out[5:0]==0 throughout.
